// File: rtl/traffic_injector_pkg.sv
// Shared Hermes definitions: port identifiers, flit offsets within a packet
// header, and the task-injector service codes.
package traffic_injector_pkg;

    typedef enum logic [2:0] {
        HERMES_EAST  = 3'd0,
        HERMES_WEST  = 3'd1,
        HERMES_NORTH = 3'd2,
        HERMES_SOUTH = 3'd3,
        HERMES_LOCAL = 3'd4
    } hermes_port_e;

    localparam int unsigned FLIT_HEADER  = 0;
    localparam int unsigned FLIT_SIZE_IX = 1;
    localparam int unsigned FLIT_SERVICE = 2;
    localparam int unsigned FLIT_TASK    = 3;
    localparam int unsigned FLIT_CONS    = 4;
    localparam int unsigned HEADER_LEN   = 5;

    localparam logic [31:0] SVC_MESSAGE_REQUEST  = 32'h0000_0010;
    localparam logic [31:0] SVC_MESSAGE_DELIVERY = 32'h0000_0020;
    localparam logic [31:0] SVC_TASK_ALLOCATION  = 32'h0000_0030;

    // SIZE counts every flit after itself: the rest of the header plus payload.
    function automatic logic [31:0] size_flit(input logic [15:0] payload_len);
        return 32'(HEADER_LEN - FLIT_SERVICE) + {16'h0000, payload_len};
    endfunction

endpackage

// File: rtl/traffic_injector.sv
// Hermes packet generator: on start, sends header, size, service, task and
// consumer flits followed by an incrementing payload, under credit flow control.
module traffic_injector
    import traffic_injector_pkg::*;
#(
    parameter int unsigned  FLIT_SIZE = 32,
    parameter hermes_port_e PORT      = HERMES_EAST
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [15:0]          target_i,
    input  logic [31:0]          service_i,
    input  logic [15:0]          task_id_i,
    input  logic [15:0]          cons_id_i,
    input  logic [15:0]          payload_len_i,
    input  logic [FLIT_SIZE-1:0] seed_i,
    input  logic [63:0]          tick_cntr_i,
    output logic                 tx_o,
    output logic                 eop_o,
    output logic [FLIT_SIZE-1:0] data_o,
    input  logic                 credit_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [63:0]          header_time_o,
    output logic [31:0]          pkt_cnt_o,
    output logic [2:0]           port_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_HEADER, S_SIZE, S_SERVICE, S_TASK, S_CONS, S_PAYLOAD
    } state_e;

    state_e               state_q, state_d;
    logic [15:0]          target_q, target_d;
    logic [31:0]          service_q, service_d;
    logic [15:0]          task_q, task_d;
    logic [15:0]          cons_q, cons_d;
    logic [15:0]          len_q, len_d;
    logic [FLIT_SIZE-1:0] word_q, word_d;
    logic [15:0]          pay_cnt_q, pay_cnt_d;
    logic [63:0]          hdr_time_q, hdr_time_d;
    logic [31:0]          pkt_cnt_q, pkt_cnt_d;
    logic                 done_q, done_d;
    logic                 xfer;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            target_q   <= '0;
            service_q  <= '0;
            task_q     <= '0;
            cons_q     <= '0;
            len_q      <= '0;
            word_q     <= '0;
            pay_cnt_q  <= '0;
            hdr_time_q <= '0;
            pkt_cnt_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            service_q  <= service_d;
            task_q     <= task_d;
            cons_q     <= cons_d;
            len_q      <= len_d;
            word_q     <= word_d;
            pay_cnt_q  <= pay_cnt_d;
            hdr_time_q <= hdr_time_d;
            pkt_cnt_q  <= pkt_cnt_d;
            done_q     <= done_d;
        end
    end

    // NOTE: every signal written below gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        service_d  = service_q;
        task_d     = task_q;
        cons_d     = cons_q;
        len_d      = len_q;
        word_d     = word_q;
        pay_cnt_d  = pay_cnt_q;
        hdr_time_d = hdr_time_q;
        pkt_cnt_d  = pkt_cnt_q;
        done_d     = 1'b0;
        tx_o       = (state_q != S_IDLE);
        eop_o      = 1'b0;
        data_o     = '0;
        xfer       = tx_o && credit_i;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    target_d   = target_i;
                    service_d  = service_i;
                    task_d     = task_id_i;
                    cons_d     = cons_id_i;
                    len_d      = payload_len_i;
                    word_d     = seed_i;
                    hdr_time_d = tick_cntr_i;
                    state_d    = S_HEADER;
                end
            end
            S_HEADER: begin
                data_o = FLIT_SIZE'(target_q);
                if (xfer) state_d = S_SIZE;
            end
            S_SIZE: begin
                data_o = FLIT_SIZE'(size_flit(len_q));
                if (xfer) state_d = S_SERVICE;
            end
            S_SERVICE: begin
                data_o = FLIT_SIZE'(service_q);
                if (xfer) state_d = S_TASK;
            end
            S_TASK: begin
                data_o = FLIT_SIZE'(task_q);
                if (xfer) state_d = S_CONS;
            end
            S_CONS: begin
                data_o = FLIT_SIZE'(cons_q);
                eop_o  = (len_q == 16'd0);
                if (xfer) begin
                    pay_cnt_d = '0;
                    state_d   = eop_o ? S_IDLE : S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                data_o = word_q;
                eop_o  = (pay_cnt_q == len_q - 16'd1);
                if (xfer) begin
                    word_d    = word_q + FLIT_SIZE'(1);
                    pay_cnt_d = pay_cnt_q + 16'd1;
                    if (eop_o) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (xfer && eop_o) begin
            done_d    = 1'b1;
            pkt_cnt_d = pkt_cnt_q + 32'd1;
        end
    end

    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = done_q;
    assign header_time_o = hdr_time_q;
    assign pkt_cnt_o     = pkt_cnt_q;
    assign port_o        = PORT;

endmodule
